leds_show: RTL and testbench
============================

Name: leds_show

Overview:
- Single-LED show controller: one push-button input drives one LED output.
- The raw button is synchronised, debounced and edge-detected; each debounced press toggles the LED.
- Sits at top level next to board I/O: pushButton comes from a pad, led goes to a pad.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive clock cycles a new synchronised level must persist before it is accepted (legal range 1..65535).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, never overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pushButton  input  1  raw, asynchronous, bouncing button level; 1 = pressed.
- led  output  1  LED drive; 1 = on. Driven directly from a flop, no combinational path from pushButton.

Behaviour:
- Reset (rst=1, asynchronous):
  - sync_q1, sync_q2, stable, stable_d, led = 0.
  - Debounce counter = 0.
  - Asserting rst mid-debounce or mid-press aborts it: no toggle is pending after release.
- Synchroniser: two-flop chain, pushButton -> sync_q1 -> sync_q2. No logic between the stages.
- Debouncer:
  - If sync_q2 == stable, the counter clears to 0.
  - If sync_q2 != stable and counter == DEBOUNCE_CYCLES-1, stable <= sync_q2 and the counter clears.
  - Otherwise, the counter increments.
  - Any return to the stable level before acceptance clears the counter. Glitches shorter than DEBOUNCE_CYCLES cycles never reach stable.
  - The counter saturates by construction and never wraps.
- Edge detect: stable_d <= stable; press = stable & ~stable_d.
- LED: on press, led <= ~led; otherwise led holds.
  - Release (falling edge of stable) has no effect.
- Latency: if pushButton rises before clock edge k and stays high, then:
  - sync_q2 = 1 after edge k+1;
  - stable = 1 after edge k+1+DEBOUNCE_CYCLES;
  - led toggles after edge k+2+DEBOUNCE_CYCLES.
- Repeated presses: each accepted press toggles exactly once, regardless of hold time.
- Minimum press-to-press spacing is 2*DEBOUNCE_CYCLES cycles (press plus release must each be accepted).
- Undefined (X) pushButton is tolerated only while rst=1. After reset, the input must be a valid 0/1 level.
- DEBOUNCE_CYCLES=1: a new level is accepted on the first cycle it differs (pure sync + edge).

Decomposition:
- Shared package leds_show_pkg holds:
  - LED_ON = 1'b1 and LED_OFF = 1'b0;
  - the default debounce constant DEBOUNCE_DEFAULT = 16.
- No typedefs are needed.
- One natural sub-module, button_debouncer (clk, rst, raw_in, stable_out, rise_pulse). It contains the synchroniser, counter and edge detect.
- leds_show instantiates button_debouncer and holds only the led toggle flop.

Test Plan:
1. Reset: hold rst=1 with pushButton=X then 0; release rst -> led=0, and stays 0 for 100 cycles with pushButton=0.
2. Clean press, DEBOUNCE_CYCLES=4: raise pushButton before edge k and hold 20 cycles -> led=1 exactly after edge k+6 and stays 1. Release -> led remains 1.
3. Bounce filter, DEBOUNCE_CYCLES=4: pulse pushButton high for 3 cycles, low 3, high 2, then low -> led stays 0 and the counter never reaches 3 with a toggle.
4. Multiple presses: three clean presses (10 cycles high, 10 low each) -> led sequence 1, 0, 1. Exactly one toggle per press, none on release.
5. Async reset mid-operation: press accepted (led=1), then assert rst asynchronously between clock edges while the button is held -> led=0 immediately. After rst deasserts with the button still held, led toggles to 1 after 2+DEBOUNCE_CYCLES+1 edges (held level is a new press from the reset state).
6. DEBOUNCE_CYCLES=1: toggle pushButton every 2 cycles -> led toggles on every rising edge, 3 edges after each rise.

Source files
------------

// File: rtl/leds_show_pkg.sv
// Shared constants for the single-button LED show controller.
package leds_show_pkg;

    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

    localparam int DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/leds_show_if.sv
// Board-side pad signals of the LED show: one button in, one LED out.
interface leds_show_if;

    logic pushButton;
    logic led;

    modport master (output pushButton, input led);
    modport slave  (input pushButton, output led);

endinterface

// File: rtl/leds_show_debouncer.sv
// Button conditioning: two-flop synchroniser, persistence-count debouncer
// and rising-edge detector producing a one-cycle press pulse.
module button_debouncer
    import leds_show_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stable_next;

    // Plain flop chain so the first stage can resolve metastability undisturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw_in;
            sync_q2 <= sync_q1;
        end
    end

    // A new level is accepted only after it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the stable level restarts the count.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable;
        if (sync_q2 != stable) begin
            if (cnt == CNT_LAST) begin
                stable_next = sync_q2;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            stable   <= stable_next;
            stable_d <= stable;
        end
    end

    assign stable_out = stable;
    assign rise_pulse = stable & ~stable_d;

endmodule

// File: rtl/leds_show.sv
// Single-LED show: every debounced button press toggles the LED.
// The LED is driven straight from a flop, never combinationally from the pad.
module leds_show
    import leds_show_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    leds_show_if.slave  io
);

    logic press;
    logic unused_stable;
    logic led_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (io.pushButton),
        .stable_out (unused_stable),
        .rise_pulse (press)
    );

    // Releases never reach here: only the rising press pulse flips the LED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= LED_OFF;
        end else if (press) begin
            led_q <= ~led_q;
        end
    end

    assign io.led = led_q;

endmodule

// File: tb/tb_leds_show.sv
// Randomised and directed bench for leds_show at DEBOUNCE_CYCLES = 4, 1 and 16,
// each instance compared every cycle against a history-based reference model.
module tb_leds_show;

    logic clk;
    logic rst;

    leds_show_if ifA ();
    leds_show_if ifB ();
    leds_show_if ifC ();

    leds_show #(.DEBOUNCE_CYCLES(4))  dutA (.clk(clk), .rst(rst), .io(ifA));
    leds_show #(.DEBOUNCE_CYCLES(1))  dutB (.clk(clk), .rst(rst), .io(ifB));
    leds_show #(.DEBOUNCE_CYCLES(16)) dutC (.clk(clk), .rst(rst), .io(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int nCyc [3] = '{4, 1, 16};

    // Reference model: input history since reset; the debouncer sees the
    // sample from two edges back and accepts a level after N differing looks.
    bit inHist  [3][4096];
    int histLen [3];
    bit mStable [3];
    int mRun    [3];
    bit mPend   [3];
    bit mLed    [3];
    int holdLeft[3];

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset(input int d);
        histLen[d] = 0;
        mStable[d] = 1'b0;
        mRun[d]    = 0;
        mPend[d]   = 1'b0;
        mLed[d]    = 1'b0;
    endtask

    task automatic modelStep(input int d, input bit b);
        bit seen;
        inHist[d][histLen[d] % 4096] = b;
        seen = (histLen[d] >= 2) ? inHist[d][(histLen[d] - 2) % 4096] : 1'b0;
        histLen[d]++;
        if (mPend[d]) begin
            mLed[d]  = ~mLed[d];
            mPend[d] = 1'b0;
        end
        if (seen != mStable[d]) begin
            mRun[d]++;
            if (mRun[d] >= nCyc[d]) begin
                mStable[d] = seen;
                mRun[d]    = 0;
                if (seen) mPend[d] = 1'b1;
            end
        end else begin
            mRun[d] = 0;
        end
    endtask

    task automatic setButton(input int d, input logic v);
        case (d)
            0: ifA.pushButton = v;
            1: ifB.pushButton = v;
            default: ifC.pushButton = v;
        endcase
    endtask

    // One clock: feed the model what the DUTs see at the edge, then compare.
    task automatic applyStimulus();
        bit cur [3];
        bit rstAtEdge;
        cur[0] = ifA.pushButton;
        cur[1] = ifB.pushButton;
        cur[2] = ifC.pushButton;
        rstAtEdge = rst;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rstAtEdge) modelReset(d);
            else           modelStep(d, cur[d]);
        end
        #1;
        checkOutput("ledA", ifA.led, mLed[0]);
        checkOutput("ledB", ifB.led, mLed[1]);
        checkOutput("ledC", ifC.led, mLed[2]);
    endtask

    task automatic doReset();
        for (int d = 0; d < 3; d++) setButton(d, 1'b0);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) modelReset(d);
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        bit expB;
        bit gotIt;

        // Reset with undefined then quiet button, then 100 idle cycles.
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            setButton(d, 1'bx);
            modelReset(d);
        end
        runCycles(3);
        for (int d = 0; d < 3; d++) setButton(d, 1'b0);
        runCycles(2);
        rst = 1'b0;
        checkOutput("resetLedA", ifA.led, 1'b0);
        runCycles(100);
        checkOutput("idleLedA", ifA.led, 1'b0);
        checkOutput("idleLedC", ifC.led, 1'b0);

        // Clean press on A: edge k is the first edge seeing the high level.
        setButton(0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus();
            if (i == 6) checkOutput("latA_k5", ifA.led, 1'b0);
            if (i == 7) checkOutput("latA_k6", ifA.led, 1'b1);
        end
        setButton(0, 1'b0);
        runCycles(20);
        checkOutput("releaseA", ifA.led, 1'b1);

        // Bounces shorter than the debounce window never toggle.
        doReset();
        setButton(0, 1'b1); runCycles(3);
        setButton(0, 1'b0); runCycles(3);
        setButton(0, 1'b1); runCycles(2);
        setButton(0, 1'b0); runCycles(20);
        checkOutput("bounceA", ifA.led, 1'b0);

        // Three clean presses: 1, 0, 1 and nothing on release.
        doReset();
        for (int p = 0; p < 3; p++) begin
            setButton(0, 1'b1); runCycles(10);
            checkOutput("pressA", ifA.led, (p % 2 == 0) ? 1'b1 : 1'b0);
            setButton(0, 1'b0); runCycles(10);
            checkOutput("relA", ifA.led, (p % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Async reset while held; the held level then counts as a new press.
        doReset();
        setButton(0, 1'b1);
        gotIt = 1'b0;
        for (int i = 0; i < 40 && !gotIt; i++) begin
            applyStimulus();
            if (ifA.led === 1'b1) gotIt = 1'b1;
        end
        checkOutput("pressWaitA", gotIt, 1'b1);
        #2;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) modelReset(d);
        #1;
        checkOutput("asyncRstA", ifA.led, 1'b0);
        applyStimulus();
        #2;
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus();
            if (i == 6) checkOutput("reholdA_6", ifA.led, 1'b0);
            if (i == 7) checkOutput("reholdA_7", ifA.led, 1'b1);
        end

        // DEBOUNCE_CYCLES=1: toggle every 2 cycles, LED flips 3 edges after rise.
        doReset();
        expB = 1'b0;
        for (int p = 0; p < 6; p++) begin
            setButton(1, 1'b1);
            applyStimulus();
            applyStimulus();
            setButton(1, 1'b0);
            applyStimulus();
            checkOutput("fastB_pre", ifB.led, expB);
            expB = ~expB;
            applyStimulus();
            checkOutput("fastB_post", ifB.led, expB);
        end

        // Random levels with hold times around the debounce window.
        doReset();
        for (int d = 0; d < 3; d++) holdLeft[d] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin
                if (holdLeft[d] == 0) begin
                    setButton(d, logic'($urandom_range(0, 1)));
                    holdLeft[d] = $urandom_range(1, 3 * nCyc[d] + 2);
                end
                holdLeft[d]--;
            end
            if (c == 1500) doReset();
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
